// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage.
//
// Owns the 64-bit fetch PC, issues sequential word requests to instruction
// memory, buffers the returned words in an in-order queue, and delivers them
// to decode with the PC of each word. A redirect from a later stage flushes
// the queue. Responses to requests that were already in flight are dropped.
//
// Parameters:
//   RESET_PC     PC of the first fetch after reset
//   QUEUE_DEPTH  queue entries (power of two, >= 2); also caps outstanding requests
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   imem_req_valid_o/ready_i    fetch request handshake
//   imem_req_addr_o             word-aligned request byte address
//   imem_resp_valid_i/data_i    in-order response word, never back-pressured
//   redirect_valid_i/pc_i       flush and restart fetch at a new PC
//   instr_valid_o/ready_i       queue head handshake toward decode
//   instr_o, pc_o               head instruction word and its PC
//   fetch_exc_o                 head entry carries a misaligned-fetch exception
//
// Optional feature (macro FETCH_MISALIGN_EXC_EN):
//   defined   - a misaligned redirect target halts fetch and queues one NOP
//               entry flagged with fetch_exc_o; an aligned redirect resumes.
//   undefined - the redirect target's low two bits are ignored.

module fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        fetch_exc_o
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(QUEUE_DEPTH);

  logic [31:0]   q_data [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [63:0]   fetch_pc;
  logic [63:0]   head_pc;
  logic [31:0]   instr_hold;
  logic          halted;
  logic [63:0]   redirect_tgt;

  logic [CW+1:0] credit_sum;
  logic          head_valid;
  logic          req_valid;
  logic          req_fire;
  logic          deq;
  logic          enq;
  logic          resp_drop;

`ifdef FETCH_MISALIGN_EXC_EN
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic                   redirect_misaligned;
  logic [QUEUE_DEPTH-1:0] q_exc;

  assign redirect_misaligned = |redirect_pc_i[1:0];
  assign redirect_tgt        = redirect_pc_i;
`else
  logic [1:0] unused_pc_lsbs;

  assign unused_pc_lsbs = redirect_pc_i[1:0];
  assign redirect_tgt   = {redirect_pc_i[63:2], 2'b00};
  assign halted         = 1'b0;
`endif

  always_comb begin
    credit_sum = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop_cnt};
    head_valid = (count != '0);
    // Gated by reset so no request escapes while reset is held.
    req_valid  = !reset && !redirect_valid_i && !halted && (credit_sum < DEPTH_W);
    req_fire   = req_valid && imem_req_ready_i;
    deq        = head_valid && !redirect_valid_i && instr_ready_i;
    resp_drop  = imem_resp_valid_i && (drop_cnt != '0);
    enq        = imem_resp_valid_i && (drop_cnt == '0);
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc;
  assign instr_valid_o    = head_valid && !redirect_valid_i;
  assign instr_o          = head_valid ? q_data[rd_ptr] : instr_hold;
  assign pc_o             = head_pc;

`ifdef FETCH_MISALIGN_EXC_EN
  assign fetch_exc_o = head_valid && q_exc[rd_ptr];
`else
  assign fetch_exc_o = 1'b0;
`endif

  // Control state. On redirect, every response still owed by memory (the
  // outstanding ones plus those already marked for dropping) must be
  // discarded, less the one landing on this very edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      instr_hold  <= '0;
    end else if (redirect_valid_i) begin
      fetch_pc    <= redirect_tgt;
      head_pc     <= redirect_tgt;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      drop_cnt    <= drop_cnt + outstanding - CW'(imem_resp_valid_i);
      outstanding <= '0;
`ifdef FETCH_MISALIGN_EXC_EN
      if (redirect_misaligned) begin
        wr_ptr <= AW'(1);
        count  <= CW'(1);
      end
`endif
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 64'd4;
      if (deq) begin
        head_pc    <= head_pc + 64'd4;
        rd_ptr     <= rd_ptr + 1'b1;
        instr_hold <= q_data[rd_ptr];
      end
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
      count       <= count + CW'(enq) - CW'(deq);
      outstanding <= outstanding + CW'(req_fire) - CW'(enq);
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (!redirect_valid_i && enq) q_data[wr_ptr] <= imem_resp_data_i;
`ifdef FETCH_MISALIGN_EXC_EN
    if (redirect_valid_i && redirect_misaligned) q_data[0] <= NOP_WORD;
`endif
  end

`ifdef FETCH_MISALIGN_EXC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
      q_exc  <= '0;
    end else if (redirect_valid_i) begin
      halted <= redirect_misaligned;
      q_exc  <= {{(QUEUE_DEPTH-1){1'b0}}, redirect_misaligned};
    end else if (enq) begin
      q_exc[wr_ptr] <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage and feeds it one 32-bit instruction word plus its PC per handshake.
- Owns the 64-bit fetch PC and issues sequential word requests to instruction memory.
- Buffers returned words in a small in-order queue.
- Accepts redirects (branch/jump/trap targets) from later stages, which flush buffered and in-flight instructions.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC of the first fetch after reset.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, >= 2; also the cap on outstanding memory requests.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts request.
- imem_req_addr_o  output  64  request byte address; always word aligned.
- imem_resp_valid_i  input  1  response word valid; responses in request order; never back-pressured.
- imem_resp_data_i  input  32  response instruction word.
- redirect_valid_i  input  1  redirect/flush request from a later stage.
- redirect_pc_i  input  64  redirect target.
- instr_valid_o  output  1  queue head valid toward decode.
- instr_ready_i  input  1  decode accepts head.
- instr_o  output  32  instruction word (decode's instr_i).
- pc_o  output  64  PC of instr_o.
- fetch_exc_o  output  1  head entry carries a misaligned-fetch exception.

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, head_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
  - Outputs during reset: imem_req_valid_o=0, instr_valid_o=0, instr_o=0, pc_o=RESET_PC, fetch_exc_o=0.
  - Reset mid-operation discards everything; responses to pre-reset requests must not be sent by memory.
- Credit: imem_req_valid_o = !redirect_valid_i && (occupancy + outstanding + drop_cnt < QUEUE_DEPTH) && !halted.
  - imem_req_addr_o = fetch_pc.
- Request handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^64); outstanding += 1.
- Response: if drop_cnt > 0, the word is discarded and drop_cnt -= 1. Otherwise the word is enqueued and outstanding -= 1.
  - Same-cycle request issue and response net out correctly.
- Latency: a response at edge N is visible on instr_valid_o/instr_o from cycle N+1; no combinational response-to-output path.
- Dequeue on instr_valid_o && instr_ready_i: head pops; head_pc += 4. pc_o = head_pc.
- Simultaneous enqueue and dequeue is allowed at any occupancy. Overflow cannot occur because of the credit rule. An empty queue yields instr_valid_o=0 with instr_o held.
- Redirect cycle (redirect_valid_i=1):
  - instr_valid_o forced 0 (no dequeue); imem_req_valid_o forced 0.
  - Next edge: queue flushed; fetch_pc=head_pc=redirect_pc_i.
  - drop_cnt = drop_cnt + outstanding − (1 if a response arrives this cycle); outstanding=0.
  - Next cycle: imem_req_valid_o=1 with the new PC, if credit allows.
- Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Redirect overrides a same-cycle request handshake; the memory must tolerate req_valid dropping.
- Counter widths: $clog2(QUEUE_DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_MISALIGN_EXC_EN.
- Defined: a redirect with redirect_pc_i[1:0] != 0 sets halted.
  - Queue receives one synthetic entry: instr=32'h0000_0013 (NOP), fetch_exc_o=1, pc_o = the unaligned target.
  - No memory requests are issued until the next aligned redirect clears halted.
- Not defined: redirect_pc_i[1:0] is forced to 2'b00; halted never set; fetch_exc_o tied 0.

Test Plan:
- Reset with RESET_PC=64'h8000_0000, req_ready=1, 1-cycle memory -> first request addr 64'h8000_0000, then 8000_0004, 8000_0008. First instr_valid_o at the 3rd cycle after reset release, pc_o=64'h8000_0000.
- instr_ready_i=0, memory always ready -> exactly 4 requests issued, then imem_req_valid_o stays 0. Queue holds 4 words. Raising ready drains them in order with pc_o +4 each.
- 3-cycle memory, redirect to 64'h1000 with 2 requests outstanding -> both late responses dropped. First dequeued entry has pc_o=64'h1000 and data from addr 64'h1000.
- Redirect and response in the same cycle, then a second redirect next cycle -> no stale word ever reaches instr_valid_o. drop_cnt returns to 0.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC -> next request addr wraps to 64'h0.
- With FETCH_MISALIGN_EXC_EN, redirect to 64'h1002 -> one entry with fetch_exc_o=1, pc_o=64'h1002, no requests until redirect to 64'h2000. Without the macro, requests go to 64'h1000.
